// File: rtl/cpu_pkg.sv
// Shared CPU definitions: condition codes, branch kinds and NZCV bit positions.
package cpu_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_HS = 4'b0010,
    COND_LO = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  typedef enum logic [1:0] {
    BR_B    = 2'b00,
    BR_COND = 2'b01,
    BR_CBZ  = 2'b10,
    BR_CBNZ = 2'b11
  } br_kind_e;

  localparam int N_IDX = 3;
  localparam int Z_IDX = 2;
  localparam int C_IDX = 1;
  localparam int V_IDX = 0;

  function automatic logic [3:0] pack_nzcv(input logic n, input logic z,
                                           input logic c, input logic v);
    logic [3:0] f;
    f        = 4'b0000;
    f[N_IDX] = n;
    f[Z_IDX] = z;
    f[C_IDX] = c;
    f[V_IDX] = v;
    return f;
  endfunction

endpackage

// File: rtl/cond_eval.sv
// Combinational ARM condition-code evaluator: (NZCV, cond) -> taken.
module cond_eval
  import cpu_pkg::*;
(
  input  logic [3:0] nzcv,
  input  logic [3:0] cond,
  output logic       taken
);

  logic w_n, w_z, w_c, w_v;

  assign w_n = nzcv[N_IDX];
  assign w_z = nzcv[Z_IDX];
  assign w_c = nzcv[C_IDX];
  assign w_v = nzcv[V_IDX];

  always_comb begin
    taken = 1'b1;
    case (cond_e'(cond))
      COND_EQ: taken = w_z;
      COND_NE: taken = ~w_z;
      COND_HS: taken = w_c;
      COND_LO: taken = ~w_c;
      COND_MI: taken = w_n;
      COND_PL: taken = ~w_n;
      COND_VS: taken = w_v;
      COND_VC: taken = ~w_v;
      COND_HI: taken = w_c & ~w_z;
      COND_LS: taken = ~w_c | w_z;
      COND_GE: taken = (w_n == w_v);
      COND_LT: taken = (w_n != w_v);
      COND_GT: taken = ~w_z & (w_n == w_v);
      COND_LE: taken = w_z | (w_n != w_v);
      default: taken = 1'b1;
    endcase
  end

endmodule

// File: rtl/cond_flag_unit.sv
// NZCV tracking through EX/MEM, architectural flag commit and ID-stage branch resolution.
module cond_flag_unit
  import cpu_pkg::*;
#(
  parameter bit         BYPASS_EN  = 1'b1,
  parameter logic [3:0] RESET_NZCV = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       alu_negative,
  input  logic       alu_zero,
  input  logic       alu_overflow,
  input  logic       alu_carry_out,
  input  logic       ex_valid,
  input  logic       ex_set_flags,
  input  logic       ex_flush,
  input  logic       mem_flush,
  input  logic       br_valid,
  input  logic [1:0] br_kind,
  input  logic [3:0] br_cond,
  input  logic       cbz_operand_zero,
  output logic [3:0] flags_nzcv,
  output logic       br_stall,
  output logic       take_branch,
  output logic       br_done
);

  logic [3:0] w_alu_nzcv;
  logic [3:0] w_eff_nzcv;
  logic       w_ex_src;
  logic       w_mem_src;
  logic       w_cond_taken;
  logic       w_cond_true;
  logic       w_resolve;

  logic       r_pending_vld;
  logic [3:0] r_pending_nzcv;
  logic [3:0] r_flags_nzcv;
  logic       r_take_branch;
  logic       r_br_done;

  assign w_alu_nzcv = pack_nzcv(alu_negative, alu_zero, alu_carry_out, alu_overflow);

  // A flushed producer never becomes a flag source.
  assign w_ex_src  = ex_valid & ex_set_flags & ~ex_flush;
  assign w_mem_src = r_pending_vld & ~mem_flush;

  always_comb begin
    w_eff_nzcv = r_flags_nzcv;
    if (w_ex_src)
      w_eff_nzcv = w_alu_nzcv;
    else if (w_mem_src)
      w_eff_nzcv = r_pending_nzcv;
  end

  cond_eval u_cond_eval (
    .nzcv  (w_eff_nzcv),
    .cond  (br_cond),
    .taken (w_cond_taken)
  );

  always_comb begin
    w_cond_true = 1'b1;
    case (br_kind_e'(br_kind))
      BR_B:    w_cond_true = 1'b1;
      BR_COND: w_cond_true = w_cond_taken;
      BR_CBZ:  w_cond_true = cbz_operand_zero;
      BR_CBNZ: w_cond_true = ~cbz_operand_zero;
      default: w_cond_true = 1'b1;
    endcase
  end

  // Only B.cond reads flags, so only it waits when bypassing is disabled.
  assign br_stall  = ~BYPASS_EN & br_valid & (br_kind == BR_COND) & (w_ex_src | w_mem_src);
  assign w_resolve = br_valid & ~br_stall;

  // EX -> MEM: pending flag payload, data path only
  always_ff @(posedge clk) begin
    if (w_ex_src)
      r_pending_nzcv <= w_alu_nzcv;
  end

  // EX -> MEM valid, MEM commit and branch outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pending_vld <= 1'b0;
      r_flags_nzcv  <= RESET_NZCV;
      r_take_branch <= 1'b0;
      r_br_done     <= 1'b0;
    end else begin
      r_pending_vld <= w_ex_src;
      if (w_mem_src)
        r_flags_nzcv <= r_pending_nzcv;
      r_br_done     <= w_resolve;
      r_take_branch <= w_resolve & w_cond_true;
    end
  end

  assign flags_nzcv  = r_flags_nzcv;
  assign take_branch = r_take_branch;
  assign br_done     = r_br_done;

endmodule

// File: tb/tb_cond_flag_unit.sv
// Directed bench for cond_flag_unit: bypassing and stalling instances share stimulus; taken results go through a scoreboard.
module tb_cond_flag_unit;
  import cpu_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       alu_negative, alu_zero, alu_overflow, alu_carry_out;
  logic       ex_valid, ex_set_flags, ex_flush, mem_flush;
  logic       br_valid;
  logic [1:0] br_kind;
  logic [3:0] br_cond;
  logic       cbz_operand_zero;

  logic [3:0] flags_b, flags_s;
  logic       stall_b, stall_s, take_b, take_s, done_b, done_s;

  int n_assert = 0;
  int n_fail   = 0;
  logic sb_q[$];

  always #5 clk = ~clk;

  cond_flag_unit #(.BYPASS_EN(1'b1), .RESET_NZCV(4'b0000)) dut_b (
    .clk(clk), .reset(reset),
    .alu_negative(alu_negative), .alu_zero(alu_zero),
    .alu_overflow(alu_overflow), .alu_carry_out(alu_carry_out),
    .ex_valid(ex_valid), .ex_set_flags(ex_set_flags),
    .ex_flush(ex_flush), .mem_flush(mem_flush),
    .br_valid(br_valid), .br_kind(br_kind), .br_cond(br_cond),
    .cbz_operand_zero(cbz_operand_zero),
    .flags_nzcv(flags_b), .br_stall(stall_b),
    .take_branch(take_b), .br_done(done_b)
  );

  cond_flag_unit #(.BYPASS_EN(1'b0), .RESET_NZCV(4'b0000)) dut_s (
    .clk(clk), .reset(reset),
    .alu_negative(alu_negative), .alu_zero(alu_zero),
    .alu_overflow(alu_overflow), .alu_carry_out(alu_carry_out),
    .ex_valid(ex_valid), .ex_set_flags(ex_set_flags),
    .ex_flush(ex_flush), .mem_flush(mem_flush),
    .br_valid(br_valid), .br_kind(br_kind), .br_cond(br_cond),
    .cbz_operand_zero(cbz_operand_zero),
    .flags_nzcv(flags_s), .br_stall(stall_s),
    .take_branch(take_s), .br_done(done_s)
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Drive EX stage: nzcv is {N,Z,C,V}.
  task automatic set_ex(input logic v, input logic sf, input logic fl, input logic [3:0] nzcv);
    ex_valid      = v;
    ex_set_flags  = sf;
    ex_flush      = fl;
    alu_negative  = nzcv[3];
    alu_zero      = nzcv[2];
    alu_carry_out = nzcv[1];
    alu_overflow  = nzcv[0];
  endtask

  task automatic set_br(input logic v, input logic [1:0] kind, input logic [3:0] cond, input logic cz);
    br_valid         = v;
    br_kind          = kind;
    br_cond          = cond;
    cbz_operand_zero = cz;
  endtask

  // One clock on the bypassing instance: it never stalls, so every valid branch resolves.
  task automatic cyc(input logic exp_take);
    logic exp_done;
    logic exp_t;
    exp_done = br_valid & ~reset;
    if (exp_done) sb_q.push_back(exp_take);
    @(posedge clk);
    #1;
    chk("br_done", {3'b0, done_b}, {3'b0, exp_done});
    if (done_b) begin
      exp_t = (sb_q.size() > 0) ? sb_q.pop_front() : 1'bx;
      chk("take_branch", {3'b0, take_b}, {3'b0, exp_t});
    end
  endtask

  logic [3:0] cl [8] = '{COND_HI, COND_LS, COND_GT, COND_LE, COND_LT, COND_PL, COND_EQ, COND_VC};
  logic       et [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    reset     = 1'b1;
    mem_flush = 1'b0;
    set_ex(0, 0, 0, 4'b0000);
    set_br(0, BR_B, COND_AL, 0);
    cyc(0);
    cyc(0);
    chk("rst_flags_b", flags_b, 4'b0000);
    chk("rst_flags_s", flags_s, 4'b0000);
    chk("rst_take_b", {3'b0, take_b}, 4'b0);
    reset = 1'b0;

    // B.cond AL then EQ with Z=0
    set_br(1, BR_COND, COND_AL, 0);
    #1 chk("al_stall_s", {3'b0, stall_s}, 4'b0);
    cyc(1);
    chk("al_done_s", {3'b0, done_s}, 4'b1);
    set_br(1, BR_COND, COND_EQ, 0);
    cyc(0);
    set_br(0, BR_B, COND_AL, 0);
    cyc(0);

    // ADDS 8000..0 + 8000..1 -> N0 Z0 C1 V1
    set_ex(1, 1, 0, 4'b0011);
    cyc(0);
    set_ex(0, 0, 0, 4'b0000);
    chk("adds_precommit", flags_b, 4'b0000);
    cyc(0);
    chk("adds_commit_b", flags_b, 4'b0011);
    chk("adds_commit_s", flags_s, 4'b0011);
    set_br(1, BR_COND, COND_VS, 0); cyc(1);
    set_br(1, BR_COND, COND_HS, 0); cyc(1);
    set_br(1, BR_COND, COND_GE, 0); cyc(0);
    set_br(0, BR_B, COND_AL, 0);
    cyc(0);

    // SUBS C000..0 - C000..0 -> 0110, with B.cond EQ in the same cycle
    set_ex(1, 1, 0, 4'b0110);
    set_br(1, BR_COND, COND_EQ, 0);
    #1;
    chk("subs_stall_b", {3'b0, stall_b}, 4'b0);
    chk("subs_stall_s0", {3'b0, stall_s}, 4'b1);
    cyc(1);
    chk("subs_done_s0", {3'b0, done_s}, 4'b0);
    set_ex(0, 0, 0, 4'b0000);
    #1 chk("subs_stall_s1", {3'b0, stall_s}, 4'b1);
    cyc(1);
    chk("subs_done_s1", {3'b0, done_s}, 4'b0);
    chk("subs_flags", flags_s, 4'b0110);
    #1 chk("subs_stall_s2", {3'b0, stall_s}, 4'b0);
    cyc(1);
    chk("subs_done_s2", {3'b0, done_s}, 4'b1);
    chk("subs_take_s2", {3'b0, take_s}, 4'b1);
    set_br(0, BR_B, COND_AL, 0);
    cyc(0);

    // Flushed ADDS 1+1 (0000) alongside B.cond NE: resolved on committed flags
    set_ex(1, 1, 1, 4'b0000);
    set_br(1, BR_COND, COND_NE, 0);
    #1 chk("exflush_stall_s", {3'b0, stall_s}, 4'b0);
    cyc(0);
    set_ex(0, 0, 0, 4'b0000);
    set_br(0, BR_B, COND_AL, 0);
    cyc(0);
    cyc(0);
    chk("exflush_flags", flags_b, 4'b0110);

    // Flag-setter killed in MEM is invisible and never commits
    set_ex(1, 1, 0, 4'b1000);
    cyc(0);
    set_ex(0, 0, 0, 4'b0000);
    mem_flush = 1'b1;
    set_br(1, BR_COND, COND_MI, 0);
    #1 chk("memflush_stall_s", {3'b0, stall_s}, 4'b0);
    cyc(0);
    mem_flush = 1'b0;
    set_br(0, BR_B, COND_AL, 0);
    cyc(0);
    chk("memflush_flags", flags_b, 4'b0110);

    // Remaining conditions on 0110, and the non-flag branch kinds
    for (int i = 0; i < 8; i++) begin
      set_br(1, BR_COND, cl[i], 0);
      cyc(et[i]);
    end
    set_ex(1, 1, 0, 4'b0110);
    set_br(1, BR_B, COND_EQ, 0);
    #1 chk("b_stall_s", {3'b0, stall_s}, 4'b0);
    cyc(1);
    set_br(1, BR_CBZ, COND_EQ, 1);
    #1 chk("cbz_stall_s", {3'b0, stall_s}, 4'b0);
    cyc(1);
    set_ex(0, 0, 0, 4'b0000);
    set_br(1, BR_CBZ, COND_EQ, 0);  cyc(0);
    set_br(1, BR_CBNZ, COND_EQ, 1); cyc(0);
    set_br(1, BR_CBNZ, COND_EQ, 0); cyc(1);
    set_br(0, BR_B, COND_AL, 0);
    cyc(0);

    // Back-to-back: ADDS -> 1010, then SUBS -> 0110 with B.cond MI
    set_ex(1, 1, 0, 4'b1010);
    cyc(0);
    set_ex(1, 1, 0, 4'b0110);
    set_br(1, BR_COND, COND_MI, 0);
    #1 chk("b2b_stall_s", {3'b0, stall_s}, 4'b1);
    cyc(0);
    chk("b2b_mid_flags", flags_b, 4'b1010);
    set_ex(0, 0, 0, 4'b0000);
    set_br(0, BR_B, COND_AL, 0);
    cyc(0);
    chk("b2b_final_b", flags_b, 4'b0110);
    chk("b2b_final_s", flags_s, 4'b0110);

    // Reset while a flag write and a resolved branch are in flight
    set_ex(1, 1, 0, 4'b1111);
    set_br(1, BR_B, COND_AL, 0);
    cyc(1);
    set_ex(0, 0, 0, 4'b0000);
    set_br(0, BR_B, COND_AL, 0);
    #2 reset = 1'b1;
    #1;
    chk("rst_async_done", {3'b0, done_b}, 4'b0);
    chk("rst_async_take", {3'b0, take_b}, 4'b0);
    chk("rst_async_flags", flags_b, 4'b0000);
    cyc(0);
    reset = 1'b0;
    cyc(0);
    cyc(0);
    chk("rst_nocommit_b", flags_b, 4'b0000);
    chk("rst_nocommit_s", flags_s, 4'b0000);
    chk("sb_drained", 4'(sb_q.size()), 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
